// File: rtl/button_conditioner.sv
// button_conditioner
//   Multi-channel conditioner for raw push-button / switch inputs.
//   Each channel runs an independent pipeline:
//     2-FF synchroniser -> counter debounce -> press/release one-pulses
//     -> optional hold-to-autorepeat FSM, plus a press-pulse stretcher.
//   All outputs are registered and every channel has its own private state.
//
// Ports
//   clk            in   1         single clock, everything on posedge
//   rst            in   1         synchronous, active-high reset
//   in_raw         in   CHANNELS  asynchronous raw inputs, active-high
//   level          out  CHANNELS  debounced level
//   press_pulse    out  CHANNELS  1-cycle pulse on debounced rising edge
//   release_pulse  out  CHANNELS  1-cycle pulse on debounced falling edge
//   repeat_pulse   out  CHANNELS  1-cycle autorepeat pulses while held
//   stretched_out  out  CHANNELS  press widened to STRETCH cycles

module button_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8,
    parameter int STRETCH       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] stretched_out
);

    localparam int CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int SCNT_W  = (STRETCH > 1) ? $clog2(STRETCH + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  DELAY_T   = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0]  PERIOD_T  = TMR_W'(REPEAT_PERIOD);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STRETCH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic              s1;
        logic              s2;
        logic              lvl;
        logic              prs;
        logic              rls;
        logic              rpt;
        logic              str;
        logic [CNT_W-1:0]  cnt;
        logic [TMR_W-1:0]  tmr;
        logic [SCNT_W-1:0] scnt;
        rep_state_t        state;
        logic              flip;
        logic              rise;
        logic              fall;

        // The debounced level flips on the edge where the counter has already
        // seen STABLE_CYCLES-1 disagreeing samples and the current one also
        // disagrees. rise/fall mark that edge so the pulses, the repeat FSM
        // and the stretcher all react on the very same clock as the level.
        always_comb begin
            flip = 1'b0;
            rise = 1'b0;
            fall = 1'b0;
            if ((s2 != lvl) && (cnt == CNT_LAST)) begin
                flip = 1'b1;
            end
            rise = flip && s2;
            fall = flip && !s2;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rls   <= 1'b0;
                rpt   <= 1'b0;
                str   <= 1'b0;
                cnt   <= '0;
                tmr   <= '0;
                scnt  <= '0;
                state <= ST_IDLE;
            end else begin
                s1  <= in_raw[ch];
                s2  <= s1;
                prs <= rise;
                rls <= fall;

                // Any agreeing sample restarts the stability count, so a
                // glitch shorter than STABLE_CYCLES never moves the level.
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                // stretched_out is registered from the next counter value,
                // so it rises together with press_pulse and stays up for
                // exactly STRETCH cycles. A new press simply reloads.
                if (rise) begin
                    scnt <= SCNT_LOAD;
                    str  <= 1'b1;
                end else if (scnt != '0) begin
                    scnt <= scnt - 1'b1;
                    str  <= (scnt != SCNT_ONE);
                end else begin
                    str  <= 1'b0;
                end

                // Release has priority over timer expiry, so letting go on
                // the expiry cycle produces no stray repeat pulse.
                rpt <= 1'b0;
                if (REPEAT_EN == 0) begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state <= ST_DELAY;
                                tmr   <= TMR_ONE;
                            end
                        end
                        ST_DELAY: begin
                            if (fall) begin
                                state <= ST_IDLE;
                            end else if (tmr == DELAY_T) begin
                                rpt   <= 1'b1;
                                state <= ST_REPEAT;
                                tmr   <= TMR_ONE;
                            end else begin
                                tmr <= tmr + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (fall) begin
                                state <= ST_IDLE;
                            end else if (tmr == PERIOD_T) begin
                                rpt <= 1'b1;
                                tmr <= TMR_ONE;
                            end else begin
                                tmr <= tmr + 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

        assign level[ch]         = lvl;
        assign press_pulse[ch]   = prs;
        assign release_pulse[ch] = rls;
        assign repeat_pulse[ch]  = rpt;
        assign stretched_out[ch] = str;
    end

endmodule
